// File: rtl/pc_unit.sv
// Fetch-stage program counter with stall, redirect and a circular return-address stack.
// Optional simulation trace of PC/RAS events is compiled in when PC_TRACE_EN is defined.
module pc_unit #(
    parameter int unsigned WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter int unsigned INC       = 4,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           stall,
    input  logic                           redirect,
    input  logic [WIDTH-1:0]               target,
    input  logic                           call,
    input  logic                           ret,
    output logic [WIDTH-1:0]               pc,
    output logic [$clog2(RAS_DEPTH):0]     ras_count,
    output logic                           ras_empty,
    output logic                           ras_full,
    output logic                           ras_underflow,
    output logic                           ras_overwrite
);

    localparam int unsigned SPW = $clog2(RAS_DEPTH);
    localparam int unsigned CW  = SPW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(RAS_DEPTH);

    logic [WIDTH-1:0] r_pc;
    logic [SPW-1:0]   r_sp;
    logic [CW-1:0]    r_count;
    logic             r_underflow;
    logic             r_overwrite;
    logic [WIDTH-1:0] r_ras [RAS_DEPTH];

    logic [WIDTH-1:0] w_pc_inc;
    logic [SPW-1:0]   w_top_idx;
    logic [WIDTH-1:0] w_pc_d;
    logic [SPW-1:0]   w_sp_d;
    logic [CW-1:0]    w_count_d;
    logic             w_underflow_d;
    logic             w_overwrite_d;
    logic             w_push;
    logic             w_pop;

    assign w_pc_inc  = r_pc + WIDTH'(INC);
    assign w_top_idx = r_sp - 1'b1;

    always_comb begin
        w_pc_d        = w_pc_inc;
        w_sp_d        = r_sp;
        w_count_d     = r_count;
        w_underflow_d = 1'b0;
        w_overwrite_d = 1'b0;
        w_push        = 1'b0;
        w_pop         = 1'b0;
        if (redirect) begin
            w_pc_d = target;
            if (call) begin
                w_push = 1'b1;
                w_sp_d = r_sp + 1'b1;
                // A full stack drops its oldest entry; the count saturates.
                if (r_count == FULL_CNT) begin
                    w_overwrite_d = 1'b1;
                end else begin
                    w_count_d = r_count + 1'b1;
                end
            end
        end else if (stall) begin
            w_pc_d = r_pc;
        end else if (ret) begin
            if (r_count != '0) begin
                w_pop     = 1'b1;
                w_pc_d    = r_ras[w_top_idx];
                w_sp_d    = w_top_idx;
                w_count_d = r_count - 1'b1;
            end else begin
                w_underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc        <= RESET_VEC;
            r_sp        <= '0;
            r_count     <= '0;
            r_underflow <= 1'b0;
            r_overwrite <= 1'b0;
        end else begin
            r_pc        <= w_pc_d;
            r_sp        <= w_sp_d;
            r_count     <= w_count_d;
            r_underflow <= w_underflow_d;
            r_overwrite <= w_overwrite_d;
        end
    end

    // Entry contents need no reset; the count alone marks what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ras[r_sp] <= w_pc_inc;
        end
    end

    assign pc            = r_pc;
    assign ras_count     = r_count;
    assign ras_empty     = (r_count == '0);
    assign ras_full      = (r_count == FULL_CNT);
    assign ras_underflow = r_underflow;
    assign ras_overwrite = r_overwrite;

`ifdef PC_TRACE_EN
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            $display("%0t PC::RESET", $time);
        end else begin
            if (w_pc_d != r_pc) $display("%0t PC::UPDATE pc=%h", $time, w_pc_d);
            if (w_push)         $display("%0t PC::PUSH ret=%h", $time, w_pc_inc);
            if (w_pop)          $display("%0t PC::POP ret=%h", $time, w_pc_d);
            if (w_underflow_d)  $display("%0t PC::UNDERFLOW", $time);
            if (w_overwrite_d)  $display("%0t PC::OVERWRITE", $time);
        end
    end
`else
    // Trace disabled: no simulation output is generated.
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit: a default 32-bit instance and an
// 8-bit instance with RESET_VEC=0xFC for wrap-around and asynchronous reset.
module tb_pc_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] target;
    logic        call;
    logic        ret;
    logic [31:0] pc;
    logic [2:0]  ras_count;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_underflow;
    logic        ras_overwrite;

    logic        b_rst;
    logic        b_redirect;
    logic [7:0]  b_target;
    logic        b_call;
    logic [7:0]  b_pc;
    logic [2:0]  b_ras_count;
    logic        b_ras_empty;
    logic        b_ras_full;
    logic        b_ras_underflow;
    logic        b_ras_overwrite;

    int n_checks;
    int n_errors;

    pc_unit #(
        .WIDTH(32), .RESET_VEC(32'h0), .INC(4), .RAS_DEPTH(4)
    ) u_dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .target(target),
        .call(call), .ret(ret), .pc(pc), .ras_count(ras_count), .ras_empty(ras_empty),
        .ras_full(ras_full), .ras_underflow(ras_underflow), .ras_overwrite(ras_overwrite)
    );

    pc_unit #(
        .WIDTH(8), .RESET_VEC(8'hFC), .INC(4), .RAS_DEPTH(4)
    ) u_dut_w8 (
        .clk(clk), .rst(b_rst), .stall(1'b0), .redirect(b_redirect), .target(b_target),
        .call(b_call), .ret(1'b0), .pc(b_pc), .ras_count(b_ras_count),
        .ras_empty(b_ras_empty), .ras_full(b_ras_full), .ras_underflow(b_ras_underflow),
        .ras_overwrite(b_ras_overwrite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] call_tgt [4];
    logic [31:0] ret_pc   [4];

    initial begin
        n_checks = 0;
        n_errors = 0;
        call_tgt = '{32'h20, 32'h30, 32'h40, 32'h50};
        ret_pc   = '{32'h54, 32'h44, 32'h34, 32'h24};
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; target = '0; call = 1'b0; ret = 1'b0;
        b_rst = 1'b1; b_redirect = 1'b0; b_target = '0; b_call = 1'b0;

        tick;
        tick;
        check("rst_pc", pc, 32'h0);
        check("rst_count", 32'(ras_count), 32'd0);
        check("rst_empty", 32'(ras_empty), 32'd1);
        check("rst_full", 32'(ras_full), 32'd0);
        check("rst_uf", 32'(ras_underflow), 32'd0);
        check("rst_ow", 32'(ras_overwrite), 32'd0);

        rst = 1'b0;
        check("seq_pc0", pc, 32'h0);
        tick; check("seq_pc4", pc, 32'h4);
        tick; check("seq_pc8", pc, 32'h8);
        check("seq_empty", 32'(ras_empty), 32'd1);

        stall = 1'b1;
        tick; check("stall_1", pc, 32'h8);
        tick; check("stall_2", pc, 32'h8);
        tick; check("stall_3", pc, 32'h8);
        check("stall_uf", 32'(ras_underflow), 32'd0);
        stall = 1'b0;
        tick; check("stall_rel", pc, 32'hC);

        redirect = 1'b1; stall = 1'b1; target = 32'h100;
        tick; check("redir_over_stall", pc, 32'h100);
        stall = 1'b0;

        call = 1'b1; target = 32'h200;
        tick; check("call_pc", pc, 32'h200);
        check("call_count", 32'(ras_count), 32'd1);
        redirect = 1'b0; call = 1'b0;
        tick; tick; check("idle_pc", pc, 32'h208);
        ret = 1'b1;
        tick; check("ret_pc", pc, 32'h104);
        check("ret_count", 32'(ras_count), 32'd0);
        check("ret_empty", 32'(ras_empty), 32'd1);
        ret = 1'b0;

        call = 1'b1;
        tick; check("bare_call_pc", pc, 32'h108);
        check("bare_call_count", 32'(ras_count), 32'd0);
        call = 1'b0;

        stall = 1'b1; ret = 1'b1;
        tick; check("stall_ret_pc", pc, 32'h108);
        check("stall_ret_uf", 32'(ras_underflow), 32'd0);
        stall = 1'b0; ret = 1'b0;

        redirect = 1'b1; target = 32'h10;
        tick; check("jump_pc", pc, 32'h10);
        call = 1'b1;
        for (int i = 0; i < 4; i++) begin
            target = call_tgt[i];
            tick; check("nest_pc", pc, call_tgt[i]);
            check("nest_ow", 32'(ras_overwrite), 32'd0);
        end
        check("nest_count", 32'(ras_count), 32'd4);
        check("nest_full", 32'(ras_full), 32'd1);
        target = 32'h60;
        tick; check("ovf_pc", pc, 32'h60);
        check("ovf_ow", 32'(ras_overwrite), 32'd1);
        check("ovf_count", 32'(ras_count), 32'd4);
        check("ovf_full", 32'(ras_full), 32'd1);
        redirect = 1'b0; call = 1'b0; ret = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick; check("pop_pc", pc, ret_pc[i]);
            check("pop_count", 32'(ras_count), 32'(3 - i));
            check("pop_ow", 32'(ras_overwrite), 32'd0);
        end
        tick; check("uf_pc", pc, 32'h28);
        check("uf_pulse", 32'(ras_underflow), 32'd1);
        ret = 1'b0;
        tick; check("uf_clear", 32'(ras_underflow), 32'd0);
        check("uf_next_pc", pc, 32'h2C);

        b_rst = 1'b0;
        check("w8_rst_pc", 32'(b_pc), 32'hFC);
        tick; check("w8_wrap", 32'(b_pc), 32'h00);
        tick; check("w8_pc4", 32'(b_pc), 32'h04);
        b_redirect = 1'b1; b_call = 1'b1; b_target = 8'h80;
        tick; check("w8_call_pc", 32'(b_pc), 32'h80);
        check("w8_call_count", 32'(b_ras_count), 32'd1);
        b_redirect = 1'b0; b_call = 1'b0;
        #2;
        b_rst = 1'b1;
        #1;
        check("w8_async_pc", 32'(b_pc), 32'hFC);
        check("w8_async_count", 32'(b_ras_count), 32'd0);
        check("w8_async_empty", 32'(b_ras_empty), 32'd1);
        tick;
        b_rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program-counter unit for the fetch stage. It holds the current PC and advances it by a fixed increment each cycle. It supports stall, redirect (branch/jump) and call/return through an internal circular return-address stack (RAS). Fetch reads it; decode/execute drive the control inputs.

Parameters:
WIDTH, 32, PC and target width in bits.
RESET_VEC, 0, PC value loaded on reset (WIDTH bits).
INC, 4, sequential increment added to PC.
RAS_DEPTH, 4, RAS entries; power of two, at least 2.

Ports:
clk  input  1  system clock, rising-edge active.
rst  input  1  asynchronous active-high reset.
stall  input  1  hold PC and RAS this cycle.
redirect  input  1  load target into PC.
target  input  WIDTH  redirect destination.
call  input  1  with redirect: push return address (pc+INC).
ret  input  1  pop RAS top into PC.
pc  output  WIDTH  current PC (registered).
ras_count  output  $clog2(RAS_DEPTH)+1  valid RAS entries (registered).
ras_empty  output  1  ras_count==0.
ras_full  output  1  ras_count==RAS_DEPTH.
ras_underflow  output  1  one-cycle registered pulse: ret with empty RAS.
ras_overwrite  output  1  one-cycle registered pulse: push while full.

Behaviour:
- One clock domain. Reset is asynchronous and active-high. On rst=1: pc=RESET_VEC, ras_count=0, stack pointer=0, ras_empty=1, ras_full=0, ras_underflow=0, ras_overwrite=0. RAS entry contents are don't-care.
- All state updates on the posedge of clk. pc changes one cycle after the control inputs are sampled; there is no combinational path from inputs to pc.
- Per-cycle priority, highest first:
  1. redirect=1: pc<=target, and stall is ignored. If call=1, push pc+INC (the old pc). ret is ignored.
  2. stall=1: pc, RAS and count hold; call and ret are ignored.
  3. ret=1: if ras_count>0, pc<=RAS top, then pop (sp-1, count-1). If the RAS is empty, pc<=pc+INC and ras_underflow=1 for the next cycle.
  4. Otherwise pc<=pc+INC.
- call without redirect has no effect.
- Arithmetic: pc+INC is computed modulo 2^WIDTH, so RESET_VEC near the top of the range wraps to low addresses.
- RAS is circular, indexed by sp modulo RAS_DEPTH.
  - Push writes entry[sp] and increments sp.
  - Top is entry[sp-1].
  - Push while full overwrites the oldest entry, keeps ras_count=RAS_DEPTH, and pulses ras_overwrite for one cycle.
- Pulse outputs are cleared in any cycle where their condition does not occur, including stall cycles.
- Reset mid-operation discards all RAS contents immediately (asynchronously) and takes effect regardless of stall or redirect.

Optional Feature:
PC_TRACE_EN. When defined, a simulation-only $display reports each event with $time:
- reset: "PC::RESET"
- every PC update, with the new value
- push, pop, underflow and overwrite events
When not defined, no display statements are compiled, and port behaviour is identical.

Test Plan:
- Reset → sequential fetch: assert rst for 2 cycles, then release with no controls (defaults) → pc reads 0, 4, 8, 12 on successive posedges; ras_empty=1.
- Stall: at pc=8, hold stall=1 for 3 cycles → pc stays 8; next free cycle pc=12; ras_underflow stays 0.
- Redirect over stall: at pc=12, redirect=1, stall=1, target=0x100 → pc=0x100 next cycle.
- Call/return: at pc=0x100, redirect+call, target=0x200 → pc=0x200, ras_count=1. Two idle cycles → pc=0x208. ret → pc=0x104, ras_count=0, ras_empty=1.
- Overflow/underflow (RAS_DEPTH=4): 5 nested calls from pc=0x10,0x20,0x30,0x40,0x50 → ras_overwrite pulses on the 5th call, ras_full=1. Then 5 rets → pcs 0x54,0x44,0x34,0x24, then pc+4 with ras_underflow=1 for one cycle.
- Wrap and async reset: WIDTH=8, RESET_VEC=0xFC → pc reads 0xFC then 0x00. Assert rst between edges → pc=0xFC immediately and ras_count=0.
